// File: rtl/synth_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : synth_pkg
//  Description : Shared types and widths for the polyphonic voice allocator.
//  Revision    : 1.0 - initial release
// ============================================================================
package synth_pkg;

  localparam int NOTE_W     = 7;
  localparam int VOL_W      = 8;
  localparam int NOTE_VOL_W = 16;

  // Per-slot lifecycle: OFF is free, HELD is sounding, RELEASE is decaying
  typedef enum logic [1:0] {
    OFF     = 2'd0,
    HELD    = 2'd1,
    RELEASE = 2'd2
  } voice_state_t;

  // Allocator control flow: accept, choose slot, commit
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ALLOC = 2'd1,
    APPLY = 2'd2
  } alloc_state_t;

endpackage
`default_nettype wire

// File: rtl/voice_slot.sv
`default_nettype none
// ============================================================================
//  Module      : voice_slot
//  Description : One voice slot: holds state, note and volume, and performs
//                the linear release decay on each prescaler tick.
//  Revision    : 1.0 - initial release
// ============================================================================
module voice_slot
  import synth_pkg::*;
(
  input  logic              clk,
  input  logic              i_reset_n,
  input  logic              i_load_on,
  input  logic              i_load_off,
  input  logic [NOTE_W-1:0] i_note,
  input  logic [VOL_W-1:0]  i_vol,
  input  logic              i_tick,
  output logic [1:0]        o_state,
  output logic [NOTE_W-1:0] o_note,
  output logic [VOL_W-1:0]  o_vol
);

  voice_state_t       r_state;
  logic [NOTE_W-1:0]  r_note;
  logic [VOL_W-1:0]   r_vol;

  // Allocator writes win over the decay tick; a zero-volume release slot
  // is freed on the tick after it reaches zero, keeping its note field.
  always_ff @(posedge clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state <= OFF;
      r_note  <= '0;
      r_vol   <= '0;
    end else if (i_load_on) begin
      r_state <= HELD;
      r_note  <= i_note;
      r_vol   <= i_vol;
    end else if (i_load_off) begin
      if (r_state == HELD) begin
        r_state <= RELEASE;
      end
    end else if (i_tick && (r_state == RELEASE)) begin
      if (r_vol == '0) begin
        r_state <= OFF;
      end else begin
        r_vol <= r_vol - VOL_W'(1);
      end
    end
  end

  assign o_state = r_state;
  assign o_note  = r_note;
  assign o_vol   = r_vol;

endmodule
`default_nettype wire

// File: rtl/voice_allocator.sv
`default_nettype none
// ============================================================================
//  Module      : voice_allocator
//  Description : Accepts note-on/off events, assigns them to voice slots with
//                retrigger / free-slot / least-recently-allocated stealing,
//                and drives a release-decay prescaler shared by all slots.
//  Revision    : 1.0 - initial release
// ============================================================================
module voice_allocator
  import synth_pkg::*;
#(
  parameter int NUM_VOICES  = 4,
  parameter int RELEASE_DIV = 1024
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  ev_valid,
  output logic                  ev_ready,
  input  logic                  ev_on,
  input  logic [NOTE_W-1:0]     ev_note,
  input  logic [6:0]            ev_vel,
  output logic [NOTE_VOL_W-1:0] note_vol [NUM_VOICES],
  output logic [NUM_VOICES-1:0] voice_busy
);

  localparam int IDX_W   = $clog2(NUM_VOICES);
  localparam int PRESC_W = $clog2(RELEASE_DIV);
  localparam logic [PRESC_W-1:0] c_PRESC_MAX = PRESC_W'(RELEASE_DIV - 1);
  localparam logic [IDX_W-1:0]   c_RANK_TOP  = IDX_W'(NUM_VOICES - 1);

  alloc_state_t       r_state;
  logic               r_ready;
  logic               r_on;
  logic [NOTE_W-1:0]  r_note;
  logic [6:0]         r_vel;
  logic [IDX_W-1:0]   r_tgt;
  logic               r_tgt_vld;
  logic [PRESC_W-1:0] r_presc;
  logic [IDX_W-1:0]   r_rank [NUM_VOICES];

  logic               w_tick;
  logic [1:0]         w_slot_state [NUM_VOICES];
  logic [NOTE_W-1:0]  w_slot_note  [NUM_VOICES];
  logic [VOL_W-1:0]   w_slot_vol   [NUM_VOICES];
  logic               w_match_vld, w_held_vld, w_free_vld;
  logic [IDX_W-1:0]   w_match_idx, w_held_idx, w_free_idx, w_old_idx;
  logic               w_sel_vld;
  logic [IDX_W-1:0]   w_sel_idx;
  logic               w_apply_on, w_apply_off;

  // Accept an event in IDLE, choose its slot in ALLOC, commit in APPLY.
  // A note-on with zero velocity is latched as a note-off.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= IDLE;
      r_ready   <= 1'b0;
      r_on      <= 1'b0;
      r_note    <= '0;
      r_vel     <= '0;
      r_tgt     <= '0;
      r_tgt_vld <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (ev_valid && r_ready) begin
            r_on    <= ev_on && (ev_vel != '0);
            r_note  <= ev_note;
            r_vel   <= ev_vel;
            r_ready <= 1'b0;
            r_state <= ALLOC;
          end else begin
            r_ready <= 1'b1;
          end
        end
        ALLOC: begin
          r_tgt     <= w_sel_idx;
          r_tgt_vld <= w_sel_vld;
          r_ready   <= 1'b0;
          r_state   <= APPLY;
        end
        APPLY: begin
          r_ready <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          r_ready <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  // Free-running divider; tick marks the last cycle of each period
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_presc <= '0;
    end else if (r_presc == c_PRESC_MAX) begin
      r_presc <= '0;
    end else begin
      r_presc <= r_presc + PRESC_W'(1);
    end
  end

  assign w_tick = (r_presc == c_PRESC_MAX);

  // Scan slots for the lowest-index live match, held match, free slot, and the oldest rank
  always_comb begin
    w_match_vld = 1'b0;
    w_match_idx = '0;
    w_held_vld  = 1'b0;
    w_held_idx  = '0;
    w_free_vld  = 1'b0;
    w_free_idx  = '0;
    w_old_idx   = '0;
    for (int i = 0; i < NUM_VOICES; i++) begin
      if (!w_match_vld && (w_slot_state[i] != OFF) && (w_slot_note[i] == r_note)) begin
        w_match_vld = 1'b1;
        w_match_idx = IDX_W'(i);
      end
      if (!w_held_vld && (w_slot_state[i] == HELD) && (w_slot_note[i] == r_note)) begin
        w_held_vld = 1'b1;
        w_held_idx = IDX_W'(i);
      end
      if (!w_free_vld && (w_slot_state[i] == OFF)) begin
        w_free_vld = 1'b1;
        w_free_idx = IDX_W'(i);
      end
      if (r_rank[i] == '0) begin
        w_old_idx = IDX_W'(i);
      end
    end
  end

  // Note-on: retrigger, else free slot, else steal oldest. Note-off: held match only.
  always_comb begin
    w_sel_vld = 1'b1;
    w_sel_idx = w_old_idx;
    if (!r_on) begin
      w_sel_vld = w_held_vld;
      w_sel_idx = w_held_idx;
    end else if (w_match_vld) begin
      w_sel_idx = w_match_idx;
    end else if (w_free_vld) begin
      w_sel_idx = w_free_idx;
    end
  end

  assign w_apply_on  = (r_state == APPLY) && r_on && r_tgt_vld;
  assign w_apply_off = (r_state == APPLY) && !r_on && r_tgt_vld;

  // Target becomes newest; younger slots shift down so ranks stay a permutation
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_VOICES; i++) begin
        r_rank[i] <= IDX_W'(i);
      end
    end else if (w_apply_on) begin
      for (int i = 0; i < NUM_VOICES; i++) begin
        if (IDX_W'(i) == r_tgt) begin
          r_rank[i] <= c_RANK_TOP;
        end else if (r_rank[i] > r_rank[r_tgt]) begin
          r_rank[i] <= r_rank[i] - IDX_W'(1);
        end
      end
    end
  end

  generate
    for (genvar i = 0; i < NUM_VOICES; i++) begin : g_slot
      voice_slot u_slot (
        .clk        (clk),
        .i_reset_n  (reset_n),
        .i_load_on  (w_apply_on  && (r_tgt == IDX_W'(i))),
        .i_load_off (w_apply_off && (r_tgt == IDX_W'(i))),
        .i_note     (r_note),
        .i_vol      ({r_vel, 1'b0}),
        .i_tick     (w_tick),
        .o_state    (w_slot_state[i]),
        .o_note     (w_slot_note[i]),
        .o_vol      (w_slot_vol[i])
      );
      assign note_vol[i]   = {1'b0, w_slot_note[i], w_slot_vol[i]};
      assign voice_busy[i] = (w_slot_state[i] != OFF);
    end
  endgenerate

  assign ev_ready = r_ready;

endmodule
`default_nettype wire

// File: tb/tb_voice_allocator.sv
`default_nettype none
// ============================================================================
//  Module      : tb_voice_allocator
//  Description : Directed self-checking bench for voice_allocator
//                (4 voices, release divider of 4).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_voice_allocator;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        ev_valid = 1'b0;
  logic        ev_on = 1'b0;
  logic [6:0]  ev_note = '0;
  logic [6:0]  ev_vel = '0;
  logic        ev_ready;
  logic [15:0] note_vol [4];
  logic [3:0]  voice_busy;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct packed {
    logic        on;
    logic [6:0]  note;
    logic [6:0]  vel;
    logic [3:0]  busy;
    logic [15:0] nv0;
    logic [15:0] nv1;
    logic [15:0] nv2;
    logic [15:0] nv3;
  } vec_t;

  vec_t vecs [11];

  always #5 clk = ~clk;

  voice_allocator #(.NUM_VOICES(4), .RELEASE_DIV(4)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .ev_valid   (ev_valid),
    .ev_ready   (ev_ready),
    .ev_on      (ev_on),
    .ev_note    (ev_note),
    .ev_vel     (ev_vel),
    .note_vol   (note_vol),
    .voice_busy (voice_busy)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic on, input logic [6:0] note, input logic [6:0] vel,
                              input logic [3:0] busy, input logic [15:0] n0, input logic [15:0] n1,
                              input logic [15:0] n2, input logic [15:0] n3);
    vec_t v;
    v.on = on; v.note = note; v.vel = vel; v.busy = busy;
    v.nv0 = n0; v.nv1 = n1; v.nv2 = n2; v.nv3 = n3;
    return v;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    reset_n  = 1'b0;
    ev_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // One event with handshake; checks ready low/low/high on the three following edges.
  task automatic send(input logic on, input logic [6:0] note, input logic [6:0] vel);
    int n;
    n = 0;
    @(negedge clk);
    while (!ev_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("send_ready_wait", ev_ready, 1);
    ev_valid = 1'b1; ev_on = on; ev_note = note; ev_vel = vel;
    @(posedge clk); #1;
    ev_valid = 1'b0;
    @(posedge clk); #1;
    chk("send_ready_e1", ev_ready, 0);
    @(posedge clk); #1;
    chk("send_ready_e2", ev_ready, 0);
    @(posedge clk); #1;
    chk("send_ready_e3", ev_ready, 1);
  endtask

  task automatic t_table();
    vecs[0]  = mk(1, 7'd60, 7'd100, 4'b0001, 16'h3CC8, 16'h0000, 16'h0000, 16'h0000);
    vecs[1]  = mk(1, 7'd60, 7'd64,  4'b0001, 16'h3C80, 16'h0000, 16'h0000, 16'h0000);
    vecs[2]  = mk(1, 7'd62, 7'd64,  4'b0011, 16'h3C80, 16'h3E80, 16'h0000, 16'h0000);
    vecs[3]  = mk(1, 7'd64, 7'd64,  4'b0111, 16'h3C80, 16'h3E80, 16'h4080, 16'h0000);
    vecs[4]  = mk(1, 7'd65, 7'd64,  4'b1111, 16'h3C80, 16'h3E80, 16'h4080, 16'h4180);
    vecs[5]  = mk(1, 7'd67, 7'd64,  4'b1111, 16'h4380, 16'h3E80, 16'h4080, 16'h4180);
    vecs[6]  = mk(1, 7'd69, 7'd64,  4'b1111, 16'h4380, 16'h4580, 16'h4080, 16'h4180);
    vecs[7]  = mk(0, 7'd61, 7'd0,   4'b1111, 16'h4380, 16'h4580, 16'h4080, 16'h4180);
    vecs[8]  = mk(1, 7'd64, 7'd127, 4'b1111, 16'h4380, 16'h4580, 16'h40FE, 16'h4180);
    vecs[9]  = mk(1, 7'd71, 7'd1,   4'b1111, 16'h4380, 16'h4580, 16'h40FE, 16'h4702);
    vecs[10] = mk(1, 7'd60, 7'd0,   4'b1111, 16'h4380, 16'h4580, 16'h40FE, 16'h4702);
    for (int k = 0; k < 11; k++) begin
      send(vecs[k].on, vecs[k].note, vecs[k].vel);
      chk($sformatf("v%0d_busy", k), voice_busy, vecs[k].busy);
      chk($sformatf("v%0d_nv0", k), note_vol[0], vecs[k].nv0);
      chk($sformatf("v%0d_nv1", k), note_vol[1], vecs[k].nv1);
      chk($sformatf("v%0d_nv2", k), note_vol[2], vecs[k].nv2);
      chk($sformatf("v%0d_nv3", k), note_vol[3], vecs[k].nv3);
    end
  endtask

  task automatic t_vel0();
    logic [7:0] v;
    send(1, 7'd60, 7'd64);
    send(0, 7'd61, 7'd0);
    chk("off_absent_nv0", note_vol[0], 16'h3C80);
    chk("off_absent_busy", voice_busy, 4'b0001);
    send(1, 7'd60, 7'd0);
    repeat (12) @(posedge clk);
    #1;
    v = note_vol[0][7:0];
    chk("vel0_decaying", (v == 8'd124) || (v == 8'd125), 1);
    chk("vel0_busy", voice_busy, 4'b0001);
  endtask

  task automatic t_release();
    int c127, c0, coff, bad;
    logic [7:0] prev, v;
    c127 = -1; c0 = -1; coff = -1; bad = 0;
    send(1, 7'd60, 7'd64);
    send(0, 7'd60, 7'd0);
    prev = note_vol[0][7:0];
    for (int k = 0; k < 700 && coff < 0; k++) begin
      v = note_vol[0][7:0];
      if ((v > prev) || ((prev - v) > 8'd1)) bad++;
      if (c127 < 0 && v == 8'd127) c127 = k;
      if (c0 < 0 && v == 8'd0) begin
        c0 = k;
        chk("rel_busy_at_zero", voice_busy[0], 1);
      end
      if (coff < 0 && !voice_busy[0]) coff = k;
      prev = v;
      @(posedge clk);
      #1;
    end
    chk("rel_first_tick", (c127 >= 0) && (c127 <= 3), 1);
    chk("rel_decay_span", c0 - c127, 508);
    chk("rel_off_delay", coff - c0, 4);
    chk("rel_step_errors", bad, 0);
    chk("rel_final_nv0", note_vol[0], 16'h3C00);
    chk("rel_final_busy", voice_busy, 4'b0000);
  endtask

  task automatic t_retrigger();
    int n;
    n = 0;
    send(1, 7'd60, 7'd64);
    send(0, 7'd60, 7'd0);
    while (note_vol[0][7:0] != 8'd40 && n < 1000) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("retrig_reach40", note_vol[0][7:0], 8'd40);
    send(1, 7'd60, 7'd10);
    chk("retrig_nv0", note_vol[0], 16'h3C14);
    chk("retrig_busy", voice_busy, 4'b0001);
    repeat (20) @(posedge clk);
    #1;
    chk("retrig_held_nv0", note_vol[0], 16'h3C14);
  endtask

  task automatic t_mid_reset();
    send(1, 7'd60, 7'd64);
    send(1, 7'd62, 7'd64);
    chk("mid_busy_before", voice_busy, 4'b0011);
    @(negedge clk);
    ev_valid = 1'b1; ev_on = 1'b1; ev_note = 7'd64; ev_vel = 7'd64;
    @(posedge clk); #1;
    ev_valid = 1'b0;
    #2;
    reset_n = 1'b0;
    #1;
    chk("mid_async_busy", voice_busy, 4'b0000);
    chk("mid_async_nv0", note_vol[0], 16'h0000);
    chk("mid_async_nv1", note_vol[1], 16'h0000);
    chk("mid_async_ready", ev_ready, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    chk("mid_after_busy", voice_busy, 4'b0000);
    chk("mid_after_nv2", note_vol[2], 16'h0000);
    chk("mid_after_ready", ev_ready, 1);
    send(1, 7'd65, 7'd64);
    chk("mid_fresh_nv0", note_vol[0], 16'h4180);
  endtask

  initial begin
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", ev_ready, 0);
    chk("rst_busy", voice_busy, 4'b0000);
    chk("rst_nv0", note_vol[0], 16'h0000);
    chk("rst_nv3", note_vol[3], 16'h0000);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk); #1;
    chk("rst_ready_first_clk", ev_ready, 1);

    // First-event latency: note_vol updates on the second edge after handshake
    @(negedge clk);
    ev_valid = 1'b1; ev_on = 1'b1; ev_note = 7'd60; ev_vel = 7'd100;
    @(posedge clk); #1;
    ev_valid = 1'b0;
    @(posedge clk); #1;
    chk("lat_e1_nv0", note_vol[0], 16'h0000);
    chk("lat_e1_ready", ev_ready, 0);
    @(posedge clk); #1;
    chk("lat_e2_nv0", note_vol[0], 16'h3CC8);
    chk("lat_e2_busy", voice_busy, 4'b0001);
    chk("lat_e2_ready", ev_ready, 0);
    @(posedge clk); #1;
    chk("lat_e3_ready", ev_ready, 1);

    do_reset();
    t_table();
    do_reset();
    t_vel0();
    do_reset();
    t_release();
    do_reset();
    t_retrigger();
    do_reset();
    t_mid_reset();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
